sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one asynchronous-SRAM controller (single-transfer read_req/write_req/ready interface, 17-bit word address, 16-bit data) among NUM_PORTS requesters, e.g. video fetch, CPU and ROM loader.
- Selects one requester by fixed or round-robin priority.
- Registers that requester's command and holds it stable on the controller inputs for the whole transfer.
- Detects completion from the controller's ready handshake, then returns read data and a one-cycle acknowledge to the winner.

Parameters:
NUM_PORTS, 3, number of requesters (1..8)
ADDR_W, 17, SRAM word-address width
DATA_W, 16, SRAM data width
PRIO_PORT0, 1, 1 = port 0 wins whenever requesting; 0 = pure round-robin over all ports
TIMEOUT_CYCLES, 255, maximum cycles to wait for a transfer to complete before aborting it (1..255)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_PORTS  per-port request level
we  in  NUM_PORTS  per-port direction: 1 = write, 0 = read
addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W]
wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way as addr
ack  out  NUM_PORTS  one-cycle completion pulse to the granted port
rdata  out  DATA_W  read data; valid in the ack cycle and held until the next read completes
busy  out  1  high from grant until the ack cycle inclusive
timeout_err  out  1  sticky flag, set on any aborted transfer
ctrl_read_req  out  1  read command to the controller
ctrl_write_req  out  1  write command to the controller
ctrl_addr  out  ADDR_W  registered address to the controller
ctrl_wdata  out  DATA_W  registered write data to the controller
ctrl_read_data  in  DATA_W  controller read data
ctrl_ready  in  1  controller idle and able to accept a command

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer selects port 0 next. Reset is asynchronous, so an in-flight ctrl_*_req drops at once.
- State IDLE, when any req bit is high and ctrl_ready = 1:
  - Grant one port.
  - Register its we, addr and wdata into ctrl_addr and ctrl_wdata, and latch the grant index.
  - Set busy and go to ISSUE.
  - If ctrl_ready = 0, no grant is made.
- State ISSUE: exactly one cycle with ctrl_read_req = !we or ctrl_write_req = we. Never both. Then go to WAIT_BUSY.
- State WAIT_BUSY: wait for ctrl_ready = 0, which marks the controller as having accepted the command. Then go to WAIT_DONE.
- State WAIT_DONE: wait for ctrl_ready = 1, then go to DONE.
- State DONE, one cycle:
  - ack[grant] = 1.
  - For reads, rdata <= ctrl_read_data, captured on the same edge the FSM enters DONE, so rdata is valid during the ack cycle.
  - busy = 1 during this cycle, then return to IDLE.
- ctrl_addr and ctrl_wdata stay constant from the grant until DONE exits. Requester inputs are not sampled after the grant.
- Arbitration:
  - If PRIO_PORT0 = 1 and req[0] = 1, port 0 wins.
  - Otherwise the winner is the first requesting port searching upward from (last_grant + 1) mod NUM_PORTS.
  - last_grant updates on every grant, including port-0 priority grants.
- Requester contract: hold req, we, addr and wdata until the ack cycle. The req value seen in the cycle after ack is a new request. Back-to-back transfers from one port are therefore legal; round-robin still rotates to the other ports first.
- Timeout:
  - A counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to DONE with the ack pulse but leave rdata unchanged, and set timeout_err.
  - timeout_err is cleared only by rst.
- Minimum cost per transfer: 4 cycles (grant, ISSUE, WAIT_BUSY and WAIT_DONE each ≥1 cycle, plus DONE), plus however long ctrl_ready stays low.
- Latency: with ctrl_ready low for exactly L cycles, ack occurs L+3 cycles after the grant edge.
- Mid-transfer events: changes on req or addr during a transfer are ignored. Requests made while busy wait in IDLE arbitration.

Test Plan:
1. Single read: reset, then port 1 requests addr 0x1ABCD with we = 0, against a controller model that holds ready low 6 cycles and returns 0xBEEF -> exactly one ctrl_read_req pulse, ctrl_addr = 0x1ABCD throughout, ack[1] for one cycle 9 cycles after the grant, rdata = 0xBEEF held afterwards.
2. Single write: port 2 writes 0x5A5A to 0x00010 -> exactly one ctrl_write_req pulse, ctrl_wdata = 0x5A5A stable until DONE, ctrl_read_req never asserted, rdata unchanged.
3. Round-robin: PRIO_PORT0 = 0, all three ports request continuously -> grant order 0, 1, 2, 0, 1, 2; each ack pulses once per transfer.
4. Port-0 priority: PRIO_PORT0 = 1, with ports 0 and 2 requesting continuously -> port 0 is served every transfer and port 2 starves; when port 0 drops req, port 2 is granted on the next IDLE cycle.
5. Timeout: controller model never raises ready after accepting, with TIMEOUT_CYCLES = 20 -> ack for the granted port exactly 20 cycles after WAIT_BUSY entry, timeout_err = 1 and sticky, rdata unchanged, next request still served.
6. Reset mid-transfer: assert rst during WAIT_DONE -> all outputs 0 immediately with no clock, busy = 0, no ack; the next request is granted starting from port 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one async-SRAM controller.
// Grants one port, holds its command for the transfer, then acks it.
module sram_port_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int PRIO_PORT0     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        ctrl_read_req,
  output logic                        ctrl_write_req,
  output logic [ADDR_W-1:0]           ctrl_addr,
  output logic [DATA_W-1:0]           ctrl_wdata,
  input  logic [DATA_W-1:0]           ctrl_read_data,
  input  logic                        ctrl_ready
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IW:0] NP = (IW+1)'(NUM_PORTS);
  localparam logic [IW-1:0] LAST = IW'(NUM_PORTS - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] grant, rr_next, pick;
  logic [IW:0]   sum;
  logic          hit;
  logic          ctrl_we;
  logic [7:0]    tmo_cnt;
  logic          waiting, tmo_hit, grant_en;

  // Round-robin search starts at the port after the last grant
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    sum  = '0;
    if (PRIO_PORT0 != 0 && req[0]) begin
      hit = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, rr_next} + (IW+1)'(k);
        if (sum >= NP) sum = sum - NP;
        if (!hit && req[sum[IW-1:0]]) begin
          pick = sum[IW-1:0];
          hit  = 1'b1;
        end
      end
    end
  end

  assign grant_en = (state == IDLE) && hit && ctrl_ready;
  assign waiting  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  // A normal completion wins over a timeout landing on the same edge
  assign tmo_hit  = waiting && (tmo_cnt == TMO_LAST) &&
                    !((state == WAIT_DONE) && ctrl_ready);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (grant_en) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo_hit) state_nx = DONE;
        else if (!ctrl_ready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: if (ctrl_ready || tmo_hit) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_next     <= '0;
      ctrl_we     <= 1'b0;
      ctrl_addr   <= '0;
      ctrl_wdata  <= '0;
      rdata       <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_en) begin
        grant      <= pick;
        rr_next    <= (pick == LAST) ? '0 : pick + 1'b1;
        ctrl_we    <= we[pick];
        ctrl_addr  <= addr[int'(pick)*ADDR_W +: ADDR_W];
        ctrl_wdata <= wdata[int'(pick)*DATA_W +: DATA_W];
      end
      if (state == ISSUE) tmo_cnt <= '0;
      else if (waiting) tmo_cnt <= tmo_cnt + 8'd1;
      if (state == WAIT_DONE && ctrl_ready && !ctrl_we)
        rdata <= ctrl_read_data;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  assign busy           = (state != IDLE);
  assign ctrl_read_req  = (state == ISSUE) && !ctrl_we;
  assign ctrl_write_req = (state == ISSUE) && ctrl_we;
  assign ack = (state == DONE) ? (NUM_PORTS'(1) << grant) : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: dut 0 has port-0 priority, dut 1 is pure round-robin.
// Each dut talks to its own controller model with a settable ready-low time.
module tb_sram_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 17;
  localparam int DW = 16;

  typedef struct {
    int          port;
    logic [15:0] rd;
    int          lat;
    int          nrd;
    int          nwr;
    logic [16:0] addr;
    logic [15:0] wd;
    logic        cw;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_a, req_b, we_v;
  logic [NP*AW-1:0] addr_v;
  logic [NP*DW-1:0] wdata_v;

  logic [NP-1:0] ack    [2];
  logic [DW-1:0] rdata  [2];
  logic          busy   [2];
  logic          terr   [2];
  logic          crd    [2];
  logic          cwr    [2];
  logic [AW-1:0] caddr  [2];
  logic [DW-1:0] cwd    [2];
  logic [DW-1:0] rd_val [2];
  logic          cready [2];

  int   lat_l [2];
  logic hang  [2];
  logic mpend [2];
  logic mact  [2];
  int   mcnt  [2];

  exp_t q0[$];
  exp_t q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  int          cyc   [2];
  int          nrd   [2];
  int          nwr   [2];
  logic        bprev [2];
  logic        stab  [2];
  logic [16:0] a0    [2];
  logic [15:0] w0    [2];

  sram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .PRIO_PORT0(1), .TIMEOUT_CYCLES(20)
  ) u_prio (
    .clk(clk), .rst(rst), .req(req_a), .we(we_v),
    .addr(addr_v), .wdata(wdata_v), .ack(ack[0]),
    .rdata(rdata[0]), .busy(busy[0]), .timeout_err(terr[0]),
    .ctrl_read_req(crd[0]), .ctrl_write_req(cwr[0]),
    .ctrl_addr(caddr[0]), .ctrl_wdata(cwd[0]),
    .ctrl_read_data(rd_val[0]), .ctrl_ready(cready[0])
  );

  sram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .PRIO_PORT0(0), .TIMEOUT_CYCLES(20)
  ) u_rr (
    .clk(clk), .rst(rst), .req(req_b), .we(we_v),
    .addr(addr_v), .wdata(wdata_v), .ack(ack[1]),
    .rdata(rdata[1]), .busy(busy[1]), .timeout_err(terr[1]),
    .ctrl_read_req(crd[1]), .ctrl_write_req(cwr[1]),
    .ctrl_addr(caddr[1]), .ctrl_wdata(cwd[1]),
    .ctrl_read_data(rd_val[1]), .ctrl_ready(cready[1])
  );

  // Controller: accepts a command, one cycle later drops ready for lat_l cycles
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cready[d] <= 1'b1;
        mpend[d]  <= 1'b0;
        mact[d]   <= 1'b0;
        mcnt[d]   <= 0;
      end else begin
        if (crd[d] || cwr[d]) mpend[d] <= 1'b1;
        if (mpend[d]) begin
          mpend[d]  <= 1'b0;
          mact[d]   <= 1'b1;
          cready[d] <= 1'b0;
          mcnt[d]   <= lat_l[d] - 1;
        end else if (mact[d] && !hang[d]) begin
          if (mcnt[d] != 0) mcnt[d] <= mcnt[d] - 1;
          else begin
            cready[d] <= 1'b1;
            mact[d]   <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input int d, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h", d, nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int p, input logic [15:0] rd,
                      input int lat, input int nr, input int nw,
                      input logic [16:0] a, input logic [15:0] wd,
                      input logic cw);
    exp_t e;
    e = '{p, rd, lat, nr, nw, a, wd, cw};
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int d);
    exp_t e;
    logic have;
    if (busy[d]) begin
      if (!bprev[d]) begin
        cyc[d]  = 0;
        nrd[d]  = 0;
        nwr[d]  = 0;
        a0[d]   = caddr[d];
        w0[d]   = cwd[d];
        stab[d] = 1'b1;
      end else cyc[d]++;
      if (crd[d]) nrd[d]++;
      if (cwr[d]) nwr[d]++;
      if (caddr[d] != a0[d] || cwd[d] != w0[d]) stab[d] = 1'b0;
    end
    bprev[d] = busy[d];
    if (ack[d] != '0) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d unexpected_ack: got %0h expected none", d, ack[d]);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk(d, "ack_port", 32'(ack[d]), 32'(1) << e.port);
        chk(d, "latency", cyc[d], e.lat);
        chk(d, "rdata", 32'(rdata[d]), 32'(e.rd));
        chk(d, "read_pulses", nrd[d], e.nrd);
        chk(d, "write_pulses", nwr[d], e.nwr);
        chk(d, "ctrl_addr", 32'(a0[d]), 32'(e.addr));
        chk(d, "cmd_stable", 32'(stab[d]), 32'd1);
        if (e.cw) chk(d, "ctrl_wdata", 32'(w0[d]), 32'(e.wd));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      bprev[d] = 1'b0;
      cyc[d] = 0; nrd[d] = 0; nwr[d] = 0;
      stab[d] = 1'b1; a0[d] = '0; w0[d] = '0;
    end
  end

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic set_port(input int p, input logic w,
                          input logic [16:0] a, input logic [15:0] wd);
    we_v[p] = w;
    addr_v[p*AW +: AW] = a;
    wdata_v[p*DW +: DW] = wd;
  endtask

  task automatic wait_acks(input int d, input int n, input int budget);
    int got = 0;
    int c = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (ack[d] != '0) got++;
    end
    if (got < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d wait_ack: got %0d acks expected %0d", d, got, n);
    end
  endtask

  task automatic chk_zero(input int d);
    chk(d, "rst_ack", 32'(ack[d]), 32'd0);
    chk(d, "rst_busy", 32'(busy[d]), 32'd0);
    chk(d, "rst_read_req", 32'(crd[d]), 32'd0);
    chk(d, "rst_write_req", 32'(cwr[d]), 32'd0);
    chk(d, "rst_ctrl_addr", 32'(caddr[d]), 32'd0);
    chk(d, "rst_ctrl_wdata", 32'(cwd[d]), 32'd0);
    chk(d, "rst_rdata", 32'(rdata[d]), 32'd0);
    chk(d, "rst_timeout_err", 32'(terr[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b0;
    req_a = '0; req_b = '0; we_v = '0;
    addr_v = '0; wdata_v = '0;
    lat_l[0] = 6; lat_l[1] = 6;
    hang[0] = 1'b0; hang[1] = 1'b0;
    rd_val[0] = '0; rd_val[1] = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);

    // single read, ready low 6 cycles
    rd_val[0] = 16'hBEEF;
    set_port(1, 1'b0, 17'h1ABCD, 16'h0);
    push(0, 1, 16'hBEEF, 9, 1, 0, 17'h1ABCD, 16'h0, 1'b0);
    req_a = 3'b010;
    wait_acks(0, 1, 60);
    req_a = '0;
    repeat (4) @(negedge clk);
    chk(0, "rdata_held", 32'(rdata[0]), 32'hBEEF);

    // single write leaves rdata alone
    lat_l[0] = 3;
    rd_val[0] = 16'h1111;
    set_port(2, 1'b1, 17'h00010, 16'h5A5A);
    push(0, 2, 16'hBEEF, 6, 0, 1, 17'h00010, 16'h5A5A, 1'b1);
    req_a = 3'b100;
    wait_acks(0, 1, 60);
    req_a = '0;
    repeat (4) @(negedge clk);
    chk(0, "rdata_after_write", 32'(rdata[0]), 32'hBEEF);

    // shortest transfer
    lat_l[0] = 1;
    rd_val[0] = 16'h1234;
    set_port(0, 1'b0, 17'h00777, 16'h0);
    push(0, 0, 16'h1234, 4, 1, 0, 17'h00777, 16'h0, 1'b0);
    req_a = 3'b001;
    wait_acks(0, 1, 60);
    req_a = '0;
    repeat (2) @(negedge clk);

    // round-robin, all ports continuous
    lat_l[1] = 2;
    rd_val[1] = 16'hCAFE;
    set_port(0, 1'b0, 17'h00100, 16'h0);
    set_port(1, 1'b0, 17'h00101, 16'h0);
    set_port(2, 1'b0, 17'h00102, 16'h0);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++)
        push(1, p, 16'hCAFE, 5, 1, 0, 17'h00100 + 17'(p), 16'h0, 1'b0);
    req_b = 3'b111;
    wait_acks(1, 6, 200);
    req_b = '0;
    repeat (2) @(negedge clk);

    // port 0 priority starves port 2 until it lets go
    lat_l[0] = 2;
    rd_val[0] = 16'h4444;
    for (int r = 0; r < 3; r++)
      push(0, 0, 16'h4444, 5, 1, 0, 17'h00100, 16'h0, 1'b0);
    push(0, 2, 16'h4444, 5, 1, 0, 17'h00102, 16'h0, 1'b0);
    req_a = 3'b101;
    wait_acks(0, 3, 200);
    req_a = 3'b100;
    wait_acks(0, 1, 60);
    req_a = '0;
    repeat (2) @(negedge clk);

    // controller hangs: abort after 20 wait cycles
    hang[0] = 1'b1;
    rd_val[0] = 16'h9999;
    set_port(1, 1'b0, 17'h1F00F, 16'h0);
    push(0, 1, 16'h4444, 21, 1, 0, 17'h1F00F, 16'h0, 1'b0);
    req_a = 3'b010;
    wait_acks(0, 1, 100);
    req_a = '0;
    chk(0, "timeout_err_set", 32'(terr[0]), 32'd1);
    hang[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk(0, "timeout_err_sticky", 32'(terr[0]), 32'd1);
    chk(0, "rdata_after_timeout", 32'(rdata[0]), 32'h4444);
    rd_val[0] = 16'h7777;
    push(0, 0, 16'h7777, 5, 1, 0, 17'h00100, 16'h0, 1'b0);
    req_a = 3'b001;
    wait_acks(0, 1, 60);
    req_a = '0;
    @(negedge clk);
    chk(0, "timeout_err_kept", 32'(terr[0]), 32'd1);

    // async reset in WAIT_DONE of a port-0 transfer on the rr dut
    lat_l[1] = 6;
    set_port(0, 1'b0, 17'h00ABC, 16'h0);
    req_b = 3'b001;
    c = 0;
    while (!busy[1] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(1, "grant_before_reset", 32'(busy[1]), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero(1);
    chk(0, "rst_timeout_err", 32'(terr[0]), 32'd0);
    chk(0, "rst_rdata", 32'(rdata[0]), 32'd0);
    req_b = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // pointer restarts at port 0
    rd_val[1] = 16'h5151;
    set_port(1, 1'b0, 17'h00DEF, 16'h0);
    push(1, 0, 16'h5151, 9, 1, 0, 17'h00ABC, 16'h0, 1'b0);
    push(1, 1, 16'h5151, 9, 1, 0, 17'h00DEF, 16'h0, 1'b0);
    req_b = 3'b011;
    wait_acks(1, 1, 60);
    req_b = 3'b010;
    wait_acks(1, 1, 60);
    req_b = '0;
    repeat (3) @(negedge clk);

    chk(0, "queue_drained", q0.size(), 0);
    chk(1, "queue_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
